lcdi_ctrl: RTL and testbench



---
 rtl/lcdi_ctrl_pkg.sv | 21 ++
 rtl/lcdi_addr_gen.sv | 73 +++++++
 rtl/lcdi_ctrl.sv | 104 ++++++++++
 tb/tb_lcdi_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/lcdi_ctrl_pkg.sv
// Shared definitions for the LCDI sequencer and datapath: phase codes,
// state width and default frame geometry.
package lcdi_ctrl_pkg;

  localparam int STATE_W    = 3;
  localparam int DEF_IMG_W  = 128;
  localparam int DEF_IMG_H  = 64;
  localparam int DEF_ROW_AW = 6;
  localparam int DEF_COL_AW = 7;

  // The datapath decodes these same codes, so the values are fixed.
  typedef enum logic [STATE_W-1:0] {
    IDLE = 3'd0,
    S1   = 3'd1,
    S2   = 3'd2,
    S3   = 3'd3,
    S4   = 3'd4,
    DONE = 3'd5
  } lcdi_state_e;

endpackage

// File: rtl/lcdi_addr_gen.sv
// Raster row/column counters for the LCDI sequencer.
// Also provides last-pixel detection and the mirrored upper/lower row taps.
module lcdi_addr_gen
  import lcdi_ctrl_pkg::*;
#(
  parameter int IMG_W  = DEF_IMG_W,
  parameter int IMG_H  = DEF_IMG_H,
  parameter int ROW_AW = DEF_ROW_AW,
  parameter int COL_AW = DEF_COL_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              advance_i,
  input  logic              clear_i,
  input  logic              load_taps_i,
  output logic [ROW_AW-1:0] row_o,
  output logic [ROW_AW-1:0] row_up_o,
  output logic [ROW_AW-1:0] row_dn_o,
  output logic [COL_AW-1:0] col_o,
  output logic              last_o
);

  localparam logic [ROW_AW-1:0] ROW_LAST = ROW_AW'(IMG_H - 1);
  localparam logic [COL_AW-1:0] COL_LAST = COL_AW'(IMG_W - 1);

  logic [ROW_AW-1:0] row_q, row_d;
  logic [COL_AW-1:0] col_q, col_d;
  logic [ROW_AW-1:0] up_q, up_d;
  logic [ROW_AW-1:0] dn_q, dn_d;

  // Taps are derived from the next row so they are already registered
  // in the same cycle the pixel enters its fetch phase.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clear_i) begin
      row_d = '0;
      col_d = '0;
    end else if (advance_i) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
    up_d = (row_d == '0)       ? ROW_AW'(1)        : row_d - 1'b1;
    dn_d = (row_d == ROW_LAST) ? ROW_LAST - 1'b1   : row_d + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q <= '0;
      col_q <= '0;
      up_q  <= '0;
      dn_q  <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
      if (load_taps_i) begin
        up_q <= up_d;
        dn_q <= dn_d;
      end
    end
  end

  assign row_o    = row_q;
  assign col_o    = col_q;
  assign row_up_o = up_q;
  assign row_dn_o = dn_q;
  assign last_o   = (row_q == ROW_LAST) && (col_q == COL_LAST);

endmodule

// File: rtl/lcdi_ctrl.sv
// LCDI phase sequencer: steps each pixel through fetch/upper/lower/commit,
// issuing line-buffer reads and the output write address.
module lcdi_ctrl
  import lcdi_ctrl_pkg::*;
#(
  parameter int IMG_W  = DEF_IMG_W,
  parameter int IMG_H  = DEF_IMG_H,
  parameter int ROW_AW = DEF_ROW_AW,
  parameter int COL_AW = DEF_COL_AW
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     ds_ready,
  output logic [STATE_W-1:0]       LCDI_state,
  output logic [6:0]               index,
  output logic                     rd_en,
  output logic [ROW_AW-1:0]        rd_row0,
  output logic [ROW_AW-1:0]        rd_row1,
  output logic [ROW_AW-1:0]        rd_row2,
  output logic [COL_AW-1:0]        rd_col,
  output logic [ROW_AW+COL_AW-1:0] wr_addr,
  output logic                     busy,
  output logic                     done
);

  lcdi_state_e state_q, state_d;
  logic        advance, clear, last;
  logic        rd_en_q, busy_q, done_q;
  logic [ROW_AW+COL_AW-1:0] wr_addr_q;
  logic [ROW_AW-1:0] row, row_up, row_dn;
  logic [COL_AW-1:0] col;

  lcdi_addr_gen #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .ROW_AW(ROW_AW),
    .COL_AW(COL_AW)
  ) u_addr_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .advance_i  (advance),
    .clear_i    (clear),
    .load_taps_i(state_d == S1),
    .row_o      (row),
    .row_up_o   (row_up),
    .row_dn_o   (row_dn),
    .col_o      (col),
    .last_o     (last)
  );

  // Only S1 may wait on downstream; S2..S4 feed a pipeline that cannot hold.
  always_comb begin
    state_d = state_q;
    advance = 1'b0;
    clear   = 1'b0;
    if (abort) begin
      state_d = IDLE;
      clear   = 1'b1;
    end else begin
      case (state_q)
        IDLE:    if (start) state_d = S1;
        S1:      if (ds_ready) state_d = S2;
        S2:      state_d = S3;
        S3:      state_d = S4;
        S4: begin
          advance = 1'b1;
          state_d = last ? DONE : S1;
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rd_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wr_addr_q <= '0;
    end else begin
      state_q <= state_d;
      rd_en_q <= (state_d == S1);
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_d == DONE);
      if (advance) wr_addr_q <= {row, col};
    end
  end

  assign LCDI_state = state_q;
  assign index      = 7'(col);
  assign rd_col     = col;
  assign rd_row0    = row_up;
  assign rd_row1    = row;
  assign rd_row2    = row_dn;
  assign rd_en      = rd_en_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign wr_addr    = wr_addr_q;

endmodule

// File: tb/tb_lcdi_ctrl.sv
// Directed bench for lcdi_ctrl on a 4x3 frame: raster order, mirroring,
// stalls, abort, start filtering and asynchronous reset.
module tb_lcdi_ctrl;

  logic        clk = 1'b0;
  logic        rstN;
  logic        start, abort, dsReady;
  logic [2:0]  lcdiState;
  logic [6:0]  index;
  logic        rdEn;
  logic [5:0]  rdRow0, rdRow1, rdRow2;
  logic [6:0]  rdCol;
  logic [12:0] wrAddr;
  logic        busy, done;

  int errors = 0;
  int checks = 0;
  int upTap[3];
  int dnTap[3];
  int cyc;

  lcdi_ctrl #(
    .IMG_W (4),
    .IMG_H (3),
    .ROW_AW(6),
    .COL_AW(7)
  ) dut (
    .clk       (clk),
    .rst_n     (rstN),
    .start     (start),
    .abort     (abort),
    .ds_ready  (dsReady),
    .LCDI_state(lcdiState),
    .index     (index),
    .rd_en     (rdEn),
    .rd_row0   (rdRow0),
    .rd_row1   (rdRow1),
    .rd_row2   (rdRow2),
    .rd_col    (rdCol),
    .wr_addr   (wrAddr),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic a, input logic r);
    start   = s;
    abort   = a;
    dsReady = r;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_state"}, 32'(lcdiState), 0);
    checkOutput({tag, "_index"}, 32'(index), 0);
    checkOutput({tag, "_rdEn"}, 32'(rdEn), 0);
    checkOutput({tag, "_row0"}, 32'(rdRow0), 0);
    checkOutput({tag, "_row1"}, 32'(rdRow1), 0);
    checkOutput({tag, "_row2"}, 32'(rdRow2), 0);
    checkOutput({tag, "_col"}, 32'(rdCol), 0);
    checkOutput({tag, "_wrAddr"}, 32'(wrAddr), 0);
    checkOutput({tag, "_busy"}, 32'(busy), 0);
    checkOutput({tag, "_done"}, 32'(done), 0);
  endtask

  // Entered in the S1 cycle of pixel k; leaves in the cycle after its S4.
  // Any start pulse set by the caller is dropped after the first edge.
  task automatic runPixel(input int k);
    int row, col;
    row = k / 4;
    col = k % 4;
    checkOutput($sformatf("p%0d_s1_state", k), 32'(lcdiState), 1);
    checkOutput($sformatf("p%0d_s1_rdEn", k), 32'(rdEn), 1);
    checkOutput($sformatf("p%0d_s1_busy", k), 32'(busy), 1);
    checkOutput($sformatf("p%0d_s1_done", k), 32'(done), 0);
    checkOutput($sformatf("p%0d_s1_col", k), 32'(rdCol), 32'(col));
    checkOutput($sformatf("p%0d_s1_index", k), 32'(index), 32'(col));
    checkOutput($sformatf("p%0d_row0", k), 32'(rdRow0), 32'(upTap[row]));
    checkOutput($sformatf("p%0d_row1", k), 32'(rdRow1), 32'(row));
    checkOutput($sformatf("p%0d_row2", k), 32'(rdRow2), 32'(dnTap[row]));
    if (k > 0)
      checkOutput($sformatf("p%0d_wrAddr", k), 32'(wrAddr), 32'(((k - 1) / 4) * 128 + (k - 1) % 4));
    for (int ph = 2; ph <= 4; ph++) begin
      tick();
      start = 1'b0;
      checkOutput($sformatf("p%0d_ph%0d_state", k, ph), 32'(lcdiState), 32'(ph));
      checkOutput($sformatf("p%0d_ph%0d_rdEn", k, ph), 32'(rdEn), 0);
      checkOutput($sformatf("p%0d_ph%0d_col", k, ph), 32'(rdCol), 32'(col));
      checkOutput($sformatf("p%0d_ph%0d_index", k, ph), 32'(index), 32'(col));
    end
    tick();
  endtask

  initial begin
    upTap[0] = 1; upTap[1] = 0; upTap[2] = 1;
    dnTap[0] = 1; dnTap[1] = 2; dnTap[2] = 1;

    rstN = 1'b0;
    applyStimulus(0, 0, 1);
    tick();
    tick();
    checkAllZero("reset");
    rstN = 1'b1;
    tick();
    checkOutput("idle_state", 32'(lcdiState), 0);
    checkOutput("idle_busy", 32'(busy), 0);

    $display("[TB] frame 1: free-running scan");
    applyStimulus(1, 0, 1);
    tick();
    start = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (k == 3) start = 1'b1;
      runPixel(k);
    end
    checkOutput("f1_done_state", 32'(lcdiState), 5);
    checkOutput("f1_done_pulse", 32'(done), 1);
    checkOutput("f1_done_busy", 32'(busy), 1);
    checkOutput("f1_last_wrAddr", 32'(wrAddr), 2 * 128 + 3);
    applyStimulus(1, 0, 1);
    tick();
    checkOutput("f1_after_state", 32'(lcdiState), 0);
    checkOutput("f1_after_busy", 32'(busy), 0);
    checkOutput("f1_after_done", 32'(done), 0);
    applyStimulus(0, 0, 1);
    tick();
    checkOutput("startInDone_ignored", 32'(lcdiState), 0);

    $display("[TB] frame 2: stall at pixel 2");
    applyStimulus(1, 0, 1);
    tick();
    start = 1'b0;
    runPixel(0);
    runPixel(1);
    dsReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("stall%0d_state", i), 32'(lcdiState), 1);
      checkOutput($sformatf("stall%0d_col", i), 32'(rdCol), 2);
      checkOutput($sformatf("stall%0d_index", i), 32'(index), 2);
      checkOutput($sformatf("stall%0d_rdEn", i), 32'(rdEn), 1);
    end
    dsReady = 1'b1;
    for (int k = 2; k < 12; k++) runPixel(k);
    checkOutput("f2_done_state", 32'(lcdiState), 5);
    checkOutput("f2_done_pulse", 32'(done), 1);
    tick();
    checkOutput("f2_after_state", 32'(lcdiState), 0);

    $display("[TB] frame 3: abort in S2 of pixel 7");
    applyStimulus(1, 0, 1);
    tick();
    start = 1'b0;
    for (int k = 0; k < 7; k++) runPixel(k);
    tick();
    checkOutput("abort_pre_state", 32'(lcdiState), 2);
    checkOutput("abort_pre_col", 32'(rdCol), 3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkOutput("abort_state", 32'(lcdiState), 0);
    checkOutput("abort_busy", 32'(busy), 0);
    checkOutput("abort_rdEn", 32'(rdEn), 0);
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("abort_noDone%0d", i), 32'(done), 0);
      tick();
    end

    $display("[TB] frame 4: restart after abort");
    applyStimulus(1, 0, 1);
    tick();
    start = 1'b0;
    checkOutput("restart_state", 32'(lcdiState), 1);
    checkOutput("restart_col", 32'(rdCol), 0);
    checkOutput("restart_row1", 32'(rdRow1), 0);
    checkOutput("restart_row0", 32'(rdRow0), 1);
    checkOutput("restart_row2", 32'(rdRow2), 1);
    cyc = 1;
    while (done !== 1'b1 && cyc < 200) begin
      tick();
      cyc++;
    end
    checkOutput("f4_doneCycle", 32'(cyc), 49);
    tick();
    checkOutput("f4_idle", 32'(lcdiState), 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("f5_startAfterDone", 32'(lcdiState), 1);

    $display("[TB] frame 5: async reset at pixel 5 S3");
    for (int k = 0; k < 5; k++) runPixel(k);
    tick();
    tick();
    checkOutput("preReset_state", 32'(lcdiState), 3);
    checkOutput("preReset_col", 32'(rdCol), 1);
    checkOutput("preReset_row1", 32'(rdRow1), 1);
    rstN = 1'b0;
    #1;
    checkAllZero("midReset");
    tick();
    rstN = 1'b1;
    tick();
    applyStimulus(1, 0, 1);
    tick();
    start = 1'b0;
    checkOutput("postReset_wrAddr", 32'(wrAddr), 0);
    runPixel(0);
    runPixel(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
